multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multicycle MIPS datapath: one shared memory, IR/PC register enables, ALU reused for PC+4 and branch target.
- Sits beside the ALU decoder. Consumes the `aluop` this block drives.
- Adds over the single-cycle decode: per-instruction state sequencing, memory wait-state handshake, `bne`, and illegal-opcode trapping.

Parameters:
OPW, 6, opcode field width; opcodes below are given at 6 bits and zero-extended if OPW>6
MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1
CNT_W, 32, width of performance counters (optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  OPW  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completed current access this cycle
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
pcwrite  out  1  unconditional PC load
branch  out  1  conditional PC load, beq
branch_ne  out  1  conditional PC load, bne
iord  out  1  0: address=PC, 1: address=ALUOut
regdst  out  1  1: write rd, 0: write rt
memtoreg  out  1  1: write data=memory data reg
regwrite  out  1  register file write
alusrca  out  1  0: PC, 1: A register
alusrcb  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
aluop  out  2  00 add, 01 sub, 10 funct
pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
illegal_op  out  1  one-cycle pulse on unknown opcode
state_o  out  4  current state, debug
instr_count  out  CNT_W  retired instructions (optional)
cycle_count  out  CNT_W  cycles since reset (optional)

Behaviour:
- State register, 4-bit encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7
  - BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Outputs are combinational from state; only FETCH strobes are also gated by `mem_ready`. Every output not listed for a state is 0.
- Reset:
  - State goes to FETCH on the first clk edge with reset=1.
  - While reset=1, all strobes (memwrite, irwrite, pcwrite, branch, branch_ne, regwrite, illegal_op) are forced 0. Other outputs are the FETCH values.
- Per-state outputs and transitions:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready. Stay while mem_ready=0; go to DECODE when 1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
    - lw 100011 / sw 101011 -> MEMADR
    - R-type 000000 -> EXECUTE
    - beq 000100 / bne 000101 -> BRANCH
    - addi 001000 -> ADDIEX
    - j 000010 -> JUMP
    - other -> FETCH with illegal_op=1 for this cycle
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR (opcode still held in IR).
  - MEMRD: iord=1. Stay until mem_ready, then MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR: iord=1, memwrite=1 held until the mem_ready cycle inclusive -> FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; branch=1 if beq, branch_ne=1 if bne -> FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Cycle counts with mem_ready tied 1:
  - lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- Each wait state adds one cycle.
- MEM_HANDSHAKE=0: internal ready is 1, so wait states never occur.
- Reset mid-instruction aborts it. No register write is issued after the reset edge.
- Unreachable encodings 12–15 return to FETCH next cycle with all strobes 0.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined:
  - cycle_count increments every non-reset cycle.
  - instr_count increments on every transition into FETCH from a terminal state: MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP.
  - Illegal opcodes are not counted.
  - Both counters are cleared to 0 by reset and wrap at 2^CNT_W.
- Undefined: no counter flops; both outputs tied to 0.

Test Plan:
- reset=1 for 2 cycles, mem_ready=1 -> state_o=0, all strobes 0 during reset; first cycle after release irwrite=pcwrite=1.
- lw (100011), mem_ready=1 -> state_o sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5.
- sw (101011), mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, return to FETCH after the ready cycle; FETCH with mem_ready=0 holds irwrite=pcwrite=0.
- beq (000100) then bne (000101) -> BRANCH with branch=1/branch_ne=0, then branch=0/branch_ne=1; pcsrc=01, aluop=01.
- opcode 111111 -> DECODE to FETCH, illegal_op=1 for exactly one cycle, no regwrite/memwrite.
- MC_PERF_CNT_EN defined, program R-type, addi, j, illegal -> after 4+4+3+2=13 cycles, instr_count=3 and cycle_count=13.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath with memory wait-state handshake.
// Optional performance counters are compiled in with `define MC_PERF_CNT_EN.
module multicycle_controller #(
  parameter int OPW           = 6,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   opcode,
  input  logic             mem_ready,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic             branch_ne,
  output logic             iord,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  // state   | meaning
  // FETCH   | read instruction, PC <= PC+4 when memory ready
  // DECODE  | read registers, precompute branch target
  // MEMADR  | compute load/store address
  // MEMRD   | load data read, waits for memory
  // MEMWB   | write load data to rt
  // MEMWR   | store data write, waits for memory
  // EXECUTE | R-type ALU operation
  // ALUWB   | write ALU result to rd
  // BRANCH  | compare and conditionally load PC (beq/bne)
  // ADDIEX  | add immediate
  // ADDIWB  | write immediate result to rt
  // JUMP    | load PC with jump target
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

  state_t state, state_nxt;
  logic   ready;

  assign ready   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = FETCH;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = ready;
        pcwrite   = ready;
        state_nxt = ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_nxt = MEMADR;
          OP_RTYPE:       state_nxt = EXECUTE;
          OP_BEQ, OP_BNE: state_nxt = BRANCH;
          OP_ADDI:        state_nxt = ADDIEX;
          OP_J:           state_nxt = JUMP;
          default: begin
            state_nxt  = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord      = 1'b1;
        state_nxt = ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        memwrite  = 1'b1;
        state_nxt = ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch    = (opcode == OP_BEQ);
        branch_ne = (opcode == OP_BNE);
      end
      ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase

    // Reset overrides the current state immediately so an aborted write never strobes.
    if (reset) begin
      state_nxt  = FETCH;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      iord       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b01;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      illegal_op = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instr_q;
  logic             retire;

  always_comb begin
    retire = 1'b0;
    if (state_nxt == FETCH) begin
      case (state)
        MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: retire = 1'b1;
        default:                                   retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle state and output vectors.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_multicycle_controller;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // bundle: memwrite irwrite pcwrite branch branch_ne iord regdst memtoreg regwrite alusrca alusrcb aluop pcsrc illegal_op
  localparam logic [16:0] F_RDY  = 17'b0_1_1_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] F_IDLE = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] DEC_IL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] MADR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] MRD    = 17'b0_0_0_0_0_1_0_0_0_0_00_00_00_0;
  localparam logic [16:0] MWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] MWR    = 17'b1_0_0_0_0_1_0_0_0_0_00_00_00_0;
  localparam logic [16:0] EXE    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] AWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] BEQ    = 17'b0_0_0_1_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] BNE    = 17'b0_0_0_0_1_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] AIEX   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] AIWB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] JMP    = 17'b0_0_1_0_0_0_0_0_0_0_00_00_10_0;

`ifdef MC_PERF_CNT_EN
  localparam logic [31:0] EXP_CYC = 32'd13;
  localparam logic [31:0] EXP_INS = 32'd3;
`else
  localparam logic [31:0] EXP_CYC = 32'd0;
  localparam logic [31:0] EXP_INS = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        memwrite, irwrite, pcwrite, branch, branch_ne, iord, regdst, memtoreg, regwrite;
  logic        alusrca, illegal_op;
  logic [1:0]  alusrcb, aluop, pcsrc;
  logic [3:0]  state_o;
  logic [31:0] instr_count, cycle_count;

  logic        nh_memwrite, nh_irwrite, nh_pcwrite, nh_branch, nh_branch_ne, nh_iord, nh_regdst;
  logic        nh_memtoreg, nh_regwrite, nh_alusrca, nh_illegal_op;
  logic [1:0]  nh_alusrcb, nh_aluop, nh_pcsrc;
  logic [3:0]  nh_state_o;
  logic [31:0] nh_instr_count, nh_cycle_count;

  logic [16:0] outs;
  assign outs = {memwrite, irwrite, pcwrite, branch, branch_ne, iord, regdst, memtoreg, regwrite,
                 alusrca, alusrcb, aluop, pcsrc, illegal_op};

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
    .branch_ne(branch_ne), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsrc(pcsrc), .illegal_op(illegal_op), .state_o(state_o),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  multicycle_controller #(.MEM_HANDSHAKE(1'b0)) dut_nh (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .memwrite(nh_memwrite), .irwrite(nh_irwrite), .pcwrite(nh_pcwrite), .branch(nh_branch),
    .branch_ne(nh_branch_ne), .iord(nh_iord), .regdst(nh_regdst), .memtoreg(nh_memtoreg),
    .regwrite(nh_regwrite), .alusrca(nh_alusrca), .alusrcb(nh_alusrcb), .aluop(nh_aluop),
    .pcsrc(nh_pcsrc), .illegal_op(nh_illegal_op), .state_o(nh_state_o),
    .instr_count(nh_instr_count), .cycle_count(nh_cycle_count)
  );

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (state_o !== 4'd0) begin
        miscompares++;
        $display("FAIL reset state[%0d]: got %0d want 0", i, state_o);
      end
      vectors++;
      if (outs !== F_IDLE) begin
        miscompares++;
        $display("FAIL reset outs[%0d]: got %b want %b", i, outs, F_IDLE);
      end
      vectors++;
      if (instr_count !== 32'd0 || cycle_count !== 32'd0) begin
        miscompares++;
        $display("FAIL reset counters[%0d]: got %0d/%0d want 0/0", i, instr_count, cycle_count);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (outs !== F_RDY) begin
      miscompares++;
      $display("FAIL release outs: got %b want %b", outs, F_RDY);
    end
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    logic        rd [7];
    logic [3:0]  es [7];
    logic [16:0] eo [7];
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0};
    eo = '{F_RDY, DEC, MADR, MRD, MWB, F_IDLE, F_IDLE};
    opcode = OP_LW;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rd[i];
      #1;
      vectors++;
      if (state_o !== es[i]) begin
        miscompares++;
        $display("FAIL lw state[%0d]: got %0d want %0d", i, state_o, es[i]);
      end
      vectors++;
      if (outs !== eo[i]) begin
        miscompares++;
        $display("FAIL lw outs[%0d]: got %b want %b", i, outs, eo[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    logic        rd [7];
    logic [3:0]  es [7];
    logic [16:0] eo [7];
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};
    eo = '{F_RDY, DEC, MADR, MRD, MRD, MWB, F_IDLE};
    opcode = OP_LW;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rd[i];
      #1;
      vectors++;
      if (state_o !== es[i]) begin
        miscompares++;
        $display("FAIL lw_wait state[%0d]: got %0d want %0d", i, state_o, es[i]);
      end
      vectors++;
      if (outs !== eo[i]) begin
        miscompares++;
        $display("FAIL lw_wait outs[%0d]: got %b want %b", i, outs, eo[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_wait();
    logic        rd [9];
    logic [3:0]  es [9];
    logic [16:0] eo [9];
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0, 4'd0};
    eo = '{F_RDY, DEC, MADR, MWR, MWR, MWR, MWR, F_IDLE, F_IDLE};
    opcode = OP_SW;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      #1;
      vectors++;
      if (state_o !== es[i]) begin
        miscompares++;
        $display("FAIL sw state[%0d]: got %0d want %0d", i, state_o, es[i]);
      end
      vectors++;
      if (outs !== eo[i]) begin
        miscompares++;
        $display("FAIL sw outs[%0d]: got %b want %b", i, outs, eo[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  op [7];
    logic        rd [7];
    logic [3:0]  es [7];
    logic [16:0] eo [7];
    op = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_BNE, OP_BNE};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    es = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8, 4'd0};
    eo = '{F_RDY, DEC, BEQ, F_RDY, DEC, BNE, F_IDLE};
    for (int i = 0; i < 7; i++) begin
      opcode = op[i];
      mem_ready = rd[i];
      #1;
      vectors++;
      if (state_o !== es[i]) begin
        miscompares++;
        $display("FAIL branch state[%0d]: got %0d want %0d", i, state_o, es[i]);
      end
      vectors++;
      if (outs !== eo[i]) begin
        miscompares++;
        $display("FAIL branch outs[%0d]: got %b want %b", i, outs, eo[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic        rd [4];
    logic [3:0]  es [4];
    logic [16:0] eo [4];
    rd = '{1'b1, 1'b1, 1'b0, 1'b0};
    es = '{4'd0, 4'd1, 4'd0, 4'd0};
    eo = '{F_RDY, DEC_IL, F_IDLE, F_IDLE};
    opcode = OP_BAD;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rd[i];
      #1;
      vectors++;
      if (state_o !== es[i]) begin
        miscompares++;
        $display("FAIL illegal state[%0d]: got %0d want %0d", i, state_o, es[i]);
      end
      vectors++;
      if (outs !== eo[i]) begin
        miscompares++;
        $display("FAIL illegal outs[%0d]: got %b want %b", i, outs, eo[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  es [5];
    logic [16:0] eo [5];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    eo = '{F_RDY, DEC, MADR, MRD, MWB};
    opcode = OP_LW;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (state_o !== es[i]) begin
        miscompares++;
        $display("FAIL reset_mid state[%0d]: got %0d want %0d", i, state_o, es[i]);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (state_o !== es[4]) begin
      miscompares++;
      $display("FAIL reset_mid wb_state: got %0d want %0d", state_o, es[4]);
    end
    vectors++;
    if (outs !== F_IDLE) begin
      miscompares++;
      $display("FAIL reset_mid wb_outs: got %b want %b", outs, F_IDLE);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (state_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_mid abort_state: got %0d want 0", state_o);
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_perf();
    logic [5:0]  op [13];
    logic [3:0]  es [13];
    logic [16:0] eo [13];
    op = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
           OP_J, OP_J, OP_J, OP_BAD, OP_BAD};
    es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd1, 4'd11, 4'd0, 4'd1};
    eo = '{F_RDY, DEC, EXE, AWB, F_RDY, DEC, AIEX, AIWB, F_RDY, DEC, JMP, F_RDY, DEC_IL};
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      opcode = op[i];
      #1;
      vectors++;
      if (state_o !== es[i]) begin
        miscompares++;
        $display("FAIL perf state[%0d]: got %0d want %0d", i, state_o, es[i]);
      end
      vectors++;
      if (outs !== eo[i]) begin
        miscompares++;
        $display("FAIL perf outs[%0d]: got %b want %b", i, outs, eo[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (state_o !== 4'd0) begin
      miscompares++;
      $display("FAIL perf end_state: got %0d want 0", state_o);
    end
    vectors++;
    if (cycle_count !== EXP_CYC) begin
      miscompares++;
      $display("FAIL perf cycle_count: got %0d want %0d", cycle_count, EXP_CYC);
    end
    vectors++;
    if (instr_count !== EXP_INS) begin
      miscompares++;
      $display("FAIL perf instr_count: got %0d want %0d", instr_count, EXP_INS);
    end
    @(negedge clk);
  endtask

  task automatic test_no_handshake();
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = OP_RTYPE;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (nh_irwrite !== 1'b1 || nh_pcwrite !== 1'b1) begin
      miscompares++;
      $display("FAIL nohs fetch_strobes: got %b%b want 11", nh_irwrite, nh_pcwrite);
    end
    vectors++;
    if (irwrite !== 1'b0 || pcwrite !== 1'b0) begin
      miscompares++;
      $display("FAIL hs fetch_gated: got %b%b want 00", irwrite, pcwrite);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (nh_state_o !== 4'd1) begin
      miscompares++;
      $display("FAIL nohs state: got %0d want 1", nh_state_o);
    end
    vectors++;
    if (state_o !== 4'd0) begin
      miscompares++;
      $display("FAIL hs hold_state: got %0d want 0", state_o);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_RTYPE;
    test_reset();
    test_lw();
    test_lw_wait();
    test_sw_wait();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_perf();
    test_no_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
